i2s_rx: RTL



---
 rtl/i2s_rx.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/i2s_rx.sv
// I2S receiver: samples SCLK/LRCLK/Din in the CLK domain, deserialises
// left/right words MSB first, and presents complete stereo pairs through a
// small ram_* register interface (LEFT, RIGHT, STATUS/CTRL).
module i2s_rx #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        SCLK,
  input  logic        LRCLK,
  input  logic        Din,
  input  logic [1:0]  ram_address,
  input  logic        ram_read,
  input  logic        ram_write,
  input  logic [31:0] ram_writedata,
  output logic [31:0] ram_readdata,
  output logic        sample_valid
);

  localparam logic [5:0] LP_W = 6'(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_SHIFT, S_WAIT} state_t;

  // synchronisers and edge detect
  logic [SYNC_STAGES-1:0] r_sclk_sync, r_lr_sync, r_din_sync;
  logic                   r_sclk_d;
  logic                   w_sclk_s, w_lr_s, w_din_s;
  logic                   w_sclk_rise;

  // serial capture state
  state_t      r_state;
  logic        r_chan;
  logic [5:0]  r_cnt;
  logic [30:0] r_shift;
  logic [31:0] r_pend_left;
  logic        r_left_done;
  logic        r_lr_prev;

  // bus-visible registers
  logic [31:0] r_left, r_right, r_rdata;
  logic        r_valid, r_ovr, r_ferr, r_en;

  logic        w_lr_edge, w_in_shift, w_last, w_done, w_ferr, w_commit;
  logic [31:0] w_word_next, w_word;
  logic [31:0] w_status;
  logic        w_unused_wd;

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_lr_s      = r_lr_sync[SYNC_STAGES-1];
  assign w_din_s     = r_din_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
  assign w_lr_edge   = w_lr_s ^ r_lr_prev;

  // Completed word: newest bit in the LSB, then left-justified for narrow widths
  assign w_word_next = {r_shift, w_din_s};
  assign w_word      = w_word_next << (32 - WIDTH);

  // The final bit of a word lands on the same rise as the next LRCLK edge
  // (one-bit I2S delay), so an edge on the last bit is a normal word end.
  assign w_in_shift = w_sclk_rise && r_en && (r_state == S_SHIFT);
  assign w_last     = (r_cnt + 6'd1) == LP_W;
  assign w_done     = w_in_shift && w_last;
  assign w_ferr     = w_in_shift && !w_last && w_lr_edge;
  assign w_commit   = w_done && r_chan && r_left_done;

  assign w_status    = {27'd0, r_en, 1'b0, r_ferr, r_ovr, r_valid};
  assign w_unused_wd = ^{ram_writedata[31:5], ram_writedata[3], ram_writedata[0]};

  assign ram_readdata = r_rdata;
  assign sample_valid = r_valid;

  // Equal-depth synchronisers keep SCLK, LRCLK and Din aligned
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_sclk_sync <= '0;
      r_lr_sync   <= '0;
      r_din_sync  <= '0;
      r_sclk_d    <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SCLK};
      r_lr_sync   <= {r_lr_sync[SYNC_STAGES-2:0], LRCLK};
      r_din_sync  <= {r_din_sync[SYNC_STAGES-2:0], Din};
      r_sclk_d    <= w_sclk_s;
    end
  end

  // Frame/word capture FSM, advancing only on synchronised SCLK rises
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state     <= S_IDLE;
      r_chan      <= 1'b0;
      r_cnt       <= 6'd0;
      r_shift     <= '0;
      r_pend_left <= '0;
      r_left_done <= 1'b0;
      r_lr_prev   <= 1'b0;
    end else begin
      if (w_sclk_rise) r_lr_prev <= w_lr_s;
      if (!r_en) begin
        r_state     <= S_IDLE;
        r_cnt       <= 6'd0;
        r_left_done <= 1'b0;
      end else if (w_sclk_rise) begin
        case (r_state)
          S_IDLE, S_WAIT: begin
            if (w_lr_edge) begin
              r_state <= S_ARM;
              r_chan  <= w_lr_s;
            end
          end
          S_ARM: begin
            if (w_lr_edge) begin
              r_chan <= w_lr_s;
            end else begin
              r_shift <= {30'd0, w_din_s};
              r_cnt   <= 6'd1;
              r_state <= S_SHIFT;
            end
          end
          S_SHIFT: begin
            if (w_last) begin
              // A right word either commits with the pending left or is
              // dropped; either way the pending left is consumed.
              if (!r_chan) begin
                r_pend_left <= w_word;
                r_left_done <= 1'b1;
              end else begin
                r_left_done <= 1'b0;
              end
              if (w_lr_edge) begin
                r_state <= S_ARM;
                r_chan  <= w_lr_s;
              end else begin
                r_state <= S_WAIT;
              end
            end else if (w_lr_edge) begin
              // Short frame: drop the partial word and any unpaired left
              r_state     <= S_ARM;
              r_chan      <= w_lr_s;
              r_left_done <= 1'b0;
            end else begin
              r_shift <= w_word_next[30:0];
              r_cnt   <= r_cnt + 6'd1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Pair commit, status flags, control writes and registered reads
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_left  <= '0;
      r_right <= '0;
      r_rdata <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
      r_ferr  <= 1'b0;
      r_en    <= 1'b0;
    end else begin
      // Clears first so that a same-cycle hardware set wins
      if (ram_read && ram_address == 2'd1) r_valid <= 1'b0;
      if (ram_write && ram_address == 2'd2) begin
        r_en <= ram_writedata[4];
        if (ram_writedata[1]) r_ovr  <= 1'b0;
        if (ram_writedata[2]) r_ferr <= 1'b0;
      end
      if (w_ferr) r_ferr <= 1'b1;
      if (w_commit) begin
        r_left  <= r_pend_left;
        r_right <= w_word;
        if (r_valid) r_ovr <= 1'b1;
        r_valid <= 1'b1;
      end
      if (ram_read) begin
        case (ram_address)
          2'd0:    r_rdata <= r_left;
          2'd1:    r_rdata <= r_right;
          2'd2:    r_rdata <= w_status;
          default: r_rdata <= 32'd0;
        endcase
      end
    end
  end

endmodule
